mem_wb_stage: RTL and testbench

//   Parametrised MEM/WB pipeline stage for the 5-stage core, between data memory and the register file.

---
 rtl/mem_wb_stage.sv | 146 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage
// Description : MEM/WB pipeline stage. Aligns and extends load data, selects
//               the writeback value on the input side and holds up to two
//               entries (head + skid) behind a registered in_ready.
//               Register-file write and forwarding outputs come from the head.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [DATA_W-1:0]     in_mem_rdata,
    input  logic [DATA_W-1:0]     in_pc_plus4,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_write,
    input  logic [1:0]            in_wb_sel,
    input  logic [1:0]            in_mem_size,
    input  logic                  in_mem_unsigned,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0]     wb_data
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_nxt;

    logic                  head_we;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [DATA_W-1:0]     head_data;
    logic                  skid_we;
    logic [REG_ADDR_W-1:0] skid_rd;
    logic [DATA_W-1:0]     skid_data;

    logic                  accept;
    logic                  pop;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_W-1:0]     load_val;
    logic [DATA_W-1:0]     new_data;
    logic                  new_we;

    assign accept = in_valid & in_ready & ~flush;
    assign pop    = out_valid & out_ready;
    assign new_we = in_reg_write & (in_rd != '0);

    // Load alignment: pick the addressed byte/half lane and extend it.
    always_comb begin
        byte_sel = 8'h00;
        case (in_alu_result[1:0])
            2'd0:    byte_sel = in_mem_rdata[7:0];
            2'd1:    byte_sel = in_mem_rdata[15:8];
            2'd2:    byte_sel = in_mem_rdata[23:16];
            default: byte_sel = in_mem_rdata[31:24];
        endcase
        half_sel = in_alu_result[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];
        case (in_mem_size)
            2'd0:    load_val = {{(DATA_W-8){~in_mem_unsigned & byte_sel[7]}}, byte_sel};
            2'd1:    load_val = {{(DATA_W-16){~in_mem_unsigned & half_sel[15]}}, half_sel};
            default: load_val = in_mem_rdata;
        endcase
    end

    // Writeback source select, resolved before the value is stored.
    always_comb begin
        case (in_wb_sel)
            2'd0:    new_data = in_alu_result;
            2'd1:    new_data = load_val;
            2'd2:    new_data = in_pc_plus4;
            default: new_data = '0;
        endcase
    end

    // Occupancy next-state; flush overrides everything.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (accept) state_nxt = ST_ONE;
            ST_ONE: begin
                if (accept && !pop)      state_nxt = ST_TWO;
                else if (pop && !accept) state_nxt = ST_EMPTY;
            end
            ST_TWO:  if (pop) state_nxt = ST_ONE;
            default: state_nxt = ST_EMPTY;
        endcase
        if (flush) state_nxt = ST_EMPTY;
    end

    // State and registered ready; ready drops only when both entries are full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != ST_TWO);
        end
    end

    // Entry storage: new data goes to head when head frees up, else to skid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_we   <= 1'b0;
            head_rd   <= '0;
            head_data <= '0;
            skid_we   <= 1'b0;
            skid_rd   <= '0;
            skid_data <= '0;
        end else begin
            if (accept && (state == ST_EMPTY || (state == ST_ONE && pop))) begin
                head_we   <= new_we;
                head_rd   <= in_rd;
                head_data <= new_data;
            end else if (state == ST_TWO && pop) begin
                head_we   <= skid_we;
                head_rd   <= skid_rd;
                head_data <= skid_data;
            end
            if (accept && state == ST_ONE && !pop) begin
                skid_we   <= new_we;
                skid_rd   <= in_rd;
                skid_data <= new_data;
            end
        end
    end

    assign out_valid = (state != ST_EMPTY);
    assign wb_rd     = head_rd;
    assign wb_data   = head_data;
    assign wb_we     = out_valid & out_ready & head_we;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Self-checking bench for mem_wb_stage against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_rdata;
    logic [31:0] in_pc_plus4;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic [1:0]  in_wb_sel;
    logic [1:0]  in_mem_size;
    logic        in_mem_unsigned;
    logic        out_valid;
    logic        out_ready;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int tests = 0;
    int fails = 0;
    entry_t q[$];

    mem_wb_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
        .in_pc_plus4(in_pc_plus4), .in_rd(in_rd), .in_reg_write(in_reg_write),
        .in_wb_sel(in_wb_sel), .in_mem_size(in_mem_size),
        .in_mem_unsigned(in_mem_unsigned),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Writeback value from the architectural rules, using shifts and masks.
    function automatic logic [31:0] ref_wb(input logic [1:0] sel, input logic [31:0] alu,
                                           input logic [31:0] rdata, input logic [31:0] pc,
                                           input logic [1:0] size, input logic uns);
        logic [31:0] v;
        case (sel)
            2'd0: return alu;
            2'd2: return pc;
            2'd3: return 32'd0;
            default: begin
                if (size == 2'd0) begin
                    v = (rdata >> (8 * alu[1:0])) & 32'hFF;
                    if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
                end else if (size == 2'd1) begin
                    v = (rdata >> (16 * alu[1])) & 32'hFFFF;
                    if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
                end else begin
                    v = rdata;
                end
                return v;
            end
        endcase
    endfunction

    // One clock: apply inputs, check at negedge, update model at posedge.
    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [31:0] pc, input logic [4:0] rd, input logic rw,
                         input logic [1:0] sel, input logic [1:0] size, input logic uns,
                         input logic ordy, input logic fl);
        entry_t e;
        bit     rdy_m;
        in_valid = v; in_alu_result = alu; in_mem_rdata = rdata; in_pc_plus4 = pc;
        in_rd = rd; in_reg_write = rw; in_wb_sel = sel; in_mem_size = size;
        in_mem_unsigned = uns; out_ready = ordy; flush = fl;
        @(negedge clk);
        chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
        chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
        if (q.size() != 0) begin
            chk("wb_rd", {59'd0, wb_rd}, {59'd0, q[0].rd});
            chk("wb_data", {32'd0, wb_data}, {32'd0, q[0].data});
            chk("wb_we", {63'd0, wb_we}, {63'd0, ordy & q[0].we});
        end else begin
            chk("wb_we_idle", {63'd0, wb_we}, 64'd0);
        end
        if (!rst_n) begin
            chk("rst_wb_data", {32'd0, wb_data}, 64'd0);
            chk("rst_wb_rd", {59'd0, wb_rd}, 64'd0);
        end
        @(posedge clk);
        if (!rst_n || fl) begin
            q.delete();
        end else begin
            rdy_m = (q.size() < 2);
            if (q.size() != 0 && ordy) void'(q.pop_front());
            if (v && rdy_m) begin
                e.we   = rw & (rd != 5'd0);
                e.rd   = rd;
                e.data = ref_wb(sel, alu, rdata, pc, size, uns);
                q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, ordy, 1'b0);
    endtask

    task automatic rand_cycle();
        logic [31:0] sz;
        sz = $urandom_range(0, 3);
        drive(($urandom_range(0, 3) != 0), $urandom, $urandom, $urandom,
              5'($urandom_range(0, 31)), 1'($urandom), 2'($urandom_range(0, 3)),
              sz[1:0], 1'($urandom), ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 15) == 0));
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_alu_result = '0; in_mem_rdata = '0; in_pc_plus4 = '0; in_rd = '0;
        in_reg_write = 1'b0; in_wb_sel = '0; in_mem_size = '0; in_mem_unsigned = 1'b0;

        // Reset held while the MEM stage presents work.
        drive(1'b1, 32'h55, 32'h0, 32'h0, 5'd7, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 32'h55, 32'h0, 32'h0, 5'd7, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        idle(1'b1);

        // Back-to-back ALU stream, latency one.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'h11 * i, 32'h0, 32'h0, 5'(i), 1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
            chk("stream_data", {32'd0, wb_data}, 64'h11 * i);
        end
        idle(1'b1);

        // Load alignment examples.
        drive(1'b1, 32'h0, 32'h8000_80F0, 32'h0, 5'd5, 1'b1, 2'd1, 2'd0, 1'b0, 1'b1, 1'b0);
        chk("lb_signed", {32'd0, wb_data}, 64'hFFFF_FFF0);
        drive(1'b1, 32'h0, 32'h8000_80F0, 32'h0, 5'd6, 1'b1, 2'd1, 2'd0, 1'b1, 1'b1, 1'b0);
        chk("lb_unsigned", {32'd0, wb_data}, 64'h0000_00F0);
        drive(1'b1, 32'h2, 32'h8000_80F0, 32'h0, 5'd7, 1'b1, 2'd1, 2'd1, 1'b0, 1'b1, 1'b0);
        chk("lh_signed", {32'd0, wb_data}, 64'hFFFF_8000);
        idle(1'b1);

        // Backpressure fills both entries, then drains in order.
        for (int i = 0; i < 3; i++)
            drive(1'b1, 32'hA0 + i, 32'h0, 32'h0, 5'(8 + i), 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("full_ready", {63'd0, in_ready}, 64'd0);
        idle(1'b1);
        idle(1'b1);
        chk("drained_ready", {63'd0, in_ready}, 64'd1);
        idle(1'b1);

        // Link to x0: visible but never written.
        drive(1'b1, 32'h0, 32'h0, 32'h104, 5'd0, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("link_valid", {63'd0, out_valid}, 64'd1);
        chk("link_data", {32'd0, wb_data}, 64'h104);
        out_ready = 1'b1;
        #1;
        chk("link_we", {63'd0, wb_we}, 64'd0);
        idle(1'b1);

        // Flush from the full state with a new instruction presented.
        drive(1'b1, 32'hB0, 32'h0, 32'h0, 5'd3, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hB1, 32'h0, 32'h0, 5'd4, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hB2, 32'h0, 32'h0, 5'd5, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_ready", {63'd0, in_ready}, 64'd1);
        idle(1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) rand_cycle();

        // Asynchronous reset in the middle of operation.
        drive(1'b1, 32'hC0, 32'h0, 32'h0, 5'd9, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hC1, 32'h0, 32'h0, 5'd10, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_ready", {63'd0, in_ready}, 64'd1);
        chk("arst_data", {32'd0, wb_data}, 64'd0);
        q.delete();
        idle(1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) rand_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
